// File: rtl/dual_grant_arbiter.sv
// Two-channel arbiter: 12 requesters share service channels A and B; the top two pending requests are granted each cycle.
// Optional rotating priority is enabled with the DUAL_GRANT_RR_EN macro; otherwise priority is fixed 12 > ... > 1.
//
// state | meaning
// IDLE  | channel free, may be allocated this cycle
// GRANT | channel owned by own_x until done_x or withdrawal of req[own_x]
module dual_grant_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic [12:1] req,
   input  logic        done_a,
   input  logic        done_b,
   output logic [12:1] grant_a,
   output logic [12:1] grant_b,
   output logic [3:0]  id_a,
   output logic [3:0]  id_b,
   output logic [1:0]  busy
);

   localparam int N = 12;

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t      state_a, state_a_nxt, state_b, state_b_nxt;
   logic [3:0]  own_a, own_a_nxt, own_b, own_b_nxt;
   logic [N:1]  cand;
   logic [3:0]  first, second;
   logic        rel_a, rel_b;

   function automatic logic [N:1] onehot(input logic [3:0] i);
      logic [N:1] r;
      r = '0;
      for (int k = 1; k <= N; k++) r[k] = (i == 4'(k));
      return r;
   endfunction

`ifdef DUAL_GRANT_RR_EN
   logic [3:0] ptr, ptr_nxt, last_grant;
`endif

   // grant_x mirrors onehot(own_x), so it doubles as the owner mask
   assign cand = req & ~grant_a & ~grant_b;

   always_comb begin
      int         p;
      logic [3:0] idx;
      p      = 0;
      idx    = '0;
      first  = '0;
      second = '0;
      for (int k = 0; k < N; k++) begin
`ifdef DUAL_GRANT_RR_EN
         p = int'(ptr) - k;
         if (p < 1) p = p + N;
`else
         p = N - k;
`endif
         idx = 4'(p);
         if (cand[idx]) begin
            if (first == 4'd0)       first  = idx;
            else if (second == 4'd0) second = idx;
         end
      end
   end

   always_comb begin
      state_a_nxt = state_a;
      state_b_nxt = state_b;
      own_a_nxt   = own_a;
      own_b_nxt   = own_b;
      rel_a       = (state_a == GRANT) && (done_a || !(|(req & grant_a)));
      rel_b       = (state_b == GRANT) && (done_b || !(|(req & grant_b)));

      case (state_a)
         GRANT:   if (rel_a) begin state_a_nxt = IDLE; own_a_nxt = '0; end
         default: ;
      endcase
      case (state_b)
         GRANT:   if (rel_b) begin state_b_nxt = IDLE; own_b_nxt = '0; end
         default: ;
      endcase

      // allocation looks at the current state only: a channel released this edge waits a cycle
      if (state_a == IDLE && state_b == IDLE) begin
         if (first != 4'd0)  begin state_a_nxt = GRANT; own_a_nxt = first;  end
         if (second != 4'd0) begin state_b_nxt = GRANT; own_b_nxt = second; end
      end else if (state_a == IDLE) begin
         if (first != 4'd0)  begin state_a_nxt = GRANT; own_a_nxt = first;  end
      end else if (state_b == IDLE) begin
         if (first != 4'd0)  begin state_b_nxt = GRANT; own_b_nxt = first;  end
      end
   end

`ifdef DUAL_GRANT_RR_EN
   always_comb begin
      last_grant = '0;
      if (state_a == IDLE && state_b == IDLE)
         last_grant = (second != 4'd0) ? second : first;
      else if (state_a == IDLE || state_b == IDLE)
         last_grant = first;
      ptr_nxt = ptr;
      if (last_grant != 4'd0)
         ptr_nxt = (last_grant == 4'd1) ? 4'd12 : last_grant - 4'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) ptr <= 4'd12;
      else       ptr <= ptr_nxt;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_a <= IDLE;
         state_b <= IDLE;
         own_a   <= '0;
         own_b   <= '0;
         grant_a <= '0;
         grant_b <= '0;
      end else begin
         state_a <= state_a_nxt;
         state_b <= state_b_nxt;
         own_a   <= own_a_nxt;
         own_b   <= own_b_nxt;
         grant_a <= onehot(own_a_nxt);
         grant_b <= onehot(own_b_nxt);
      end
   end

   assign id_a = own_a;
   assign id_b = own_b;
   assign busy = {state_b == GRANT, state_a == GRANT};

endmodule

// File: tb/tb_dual_grant_arbiter.sv
// Directed bench for dual_grant_arbiter: expected owners are queued as each cycle is driven and checked after the edge.
module tb_dual_grant_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [12:1] req;
   logic        done_a, done_b;
   logic [12:1] grant_a, grant_b;
   logic [3:0]  id_a, id_b;
   logic [1:0]  busy;

   typedef struct packed {
      logic [3:0]  ea;
      logic [3:0]  eb;
      logic [12:1] ga;
      logic [12:1] gb;
      logic [1:0]  bs;
   } exp_t;

   exp_t  exp_q[$];
   string tag_q[$];
   int    n_checks = 0;
   int    n_pass   = 0;

   dual_grant_arbiter dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .done_a  (done_a),
      .done_b  (done_b),
      .grant_a (grant_a),
      .grant_b (grant_b),
      .id_a    (id_a),
      .id_b    (id_b),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [12:1] oh(input logic [3:0] i);
      logic [12:1] r;
      r = '0;
      if (i != 4'd0) r[i] = 1'b1;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
   endtask

   // drive one cycle of inputs, queue the expected owners after the edge, then check them
   task automatic cyc(input string tag, input logic rst, input logic [12:1] rq,
                      input logic da, input logic db, input logic [3:0] ea, input logic [3:0] eb);
      exp_t e;
      exp_t got;
      string t;
      reset  = rst;
      req    = rq;
      done_a = da;
      done_b = db;
      e.ea = ea;
      e.eb = eb;
      e.ga = oh(ea);
      e.gb = oh(eb);
      e.bs = {eb != 4'd0, ea != 4'd0};
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      got = exp_q.pop_front();
      t   = tag_q.pop_front();
      chk({t, ".id_a"},    32'(id_a),    32'(got.ea));
      chk({t, ".id_b"},    32'(id_b),    32'(got.eb));
      chk({t, ".grant_a"}, 32'(grant_a), 32'(got.ga));
      chk({t, ".grant_b"}, 32'(grant_b), 32'(got.gb));
      chk({t, ".busy"},    32'(busy),    32'(got.bs));
   endtask

   localparam logic [12:1] R1  = 12'h001;
   localparam logic [12:1] R2  = 12'h002;
   localparam logic [12:1] R3  = 12'h004;
   localparam logic [12:1] R4  = 12'h008;
   localparam logic [12:1] R5  = 12'h010;
   localparam logic [12:1] R7  = 12'h040;
   localparam logic [12:1] R9  = 12'h100;
   localparam logic [12:1] R11 = 12'h400;
   localparam logic [12:1] R12 = 12'h800;

   initial begin
      logic [3:0] rr2, rr3;
`ifdef DUAL_GRANT_RR_EN
      rr2 = 4'd11;
      rr3 = 4'd2;
`else
      rr2 = 4'd12;
      rr3 = 4'd12;
`endif
      reset  = 1'b1;
      req    = '0;
      done_a = 1'b0;
      done_b = 1'b0;
      #2;
      cyc("reset0", 1'b1, '0, 1'b0, 1'b0, 4'd0, 4'd0);
      cyc("reset1", 1'b1, '0, 1'b0, 1'b0, 4'd0, 4'd0);
      for (int i = 0; i < 5; i++) cyc("idle", 1'b0, '0, 1'b0, 1'b0, 4'd0, 4'd0);

      // dual grant, then B released and reallocated to the highest candidate
      cyc("dual",      1'b0, R9 | R4,       1'b0, 1'b0, 4'd9, 4'd4);
      cyc("hold",      1'b0, R9 | R4 | R12, 1'b0, 1'b0, 4'd9, 4'd4);
      cyc("done_b",    1'b0, R9 | R4 | R12, 1'b0, 1'b1, 4'd9, 4'd0);
      cyc("realloc_b", 1'b0, R9 | R4 | R12, 1'b0, 1'b0, 4'd9, 4'd12);
      cyc("both_rel",  1'b0, '0,            1'b0, 1'b0, 4'd0, 4'd0);

      // withdrawal release and ignored done in IDLE
      cyc("grant7",    1'b0, R7, 1'b0, 1'b0, 4'd7, 4'd0);
      cyc("withdraw",  1'b0, '0, 1'b0, 1'b0, 4'd0, 4'd0);
      cyc("done_idle", 1'b0, '0, 1'b1, 1'b0, 4'd0, 4'd0);

      // reset mid-grant
      cyc("grant53",   1'b0, R5 | R3, 1'b0, 1'b0, 4'd5, 4'd3);
      cyc("rst_mid",   1'b1, R5 | R3, 1'b1, 1'b1, 4'd0, 4'd0);
      cyc("regrant",   1'b0, R5 | R3, 1'b0, 1'b0, 4'd5, 4'd3);
      cyc("clear",     1'b0, '0,      1'b0, 1'b0, 4'd0, 4'd0);

      // channel A alone serves 12/11/2 while B holds requester 1
      cyc("setup",     1'b0, R2 | R1, 1'b0, 1'b0, 4'd2, 4'd1);
      cyc("a_free",    1'b0, R1,      1'b0, 1'b0, 4'd0, 4'd1);
      cyc("seq1",      1'b0, R12 | R11 | R2 | R1, 1'b0, 1'b0, 4'd12, 4'd1);
      cyc("seq1_done", 1'b0, R12 | R11 | R2 | R1, 1'b1, 1'b0, 4'd0,  4'd1);
      cyc("seq2",      1'b0, R12 | R11 | R2 | R1, 1'b0, 1'b0, rr2,   4'd1);
      cyc("seq2_done", 1'b0, R12 | R11 | R2 | R1, 1'b1, 1'b0, 4'd0,  4'd1);
      cyc("seq3",      1'b0, R12 | R11 | R2 | R1, 1'b0, 1'b0, rr3,   4'd1);
      cyc("seq3_done", 1'b0, R12 | R11 | R2 | R1, 1'b1, 1'b0, 4'd0,  4'd1);
      cyc("seq4",      1'b0, R12 | R11 | R2 | R1, 1'b0, 1'b0, 4'd12, 4'd1);
      cyc("end",       1'b0, '0, 1'b0, 1'b0, 4'd0, 4'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/dual_grant_arbiter.md
# dual_grant_arbiter

Two-channel arbiter sharing two identical service channels (A, B) among 12 requesters, built around dual-priority encoding: each cycle the highest and second-highest pending requests are selected and granted to the free channels. Grants are held until the channel owner signals completion or withdraws its request. Sits between the request sources and the shared datapath; `id_a`/`id_b` drive the channel muxes directly.

## Interface
- `N`, 12, number of requesters (indices 1..N; index 0 means "none"); fixed at 12 for this revision, `id` width 4.
- `clk`  in  1  system clock, all state updated on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  [12:1]  request lines, level-sensitive, held high until served.
- `done_a`  in  1  channel A owner finished; single-cycle pulse.
- `done_b`  in  1  channel B owner finished; single-cycle pulse.
- `grant_a`  out  [12:1]  one-hot grant for channel A, all-zero when idle.
- `grant_b`  out  [12:1]  one-hot grant for channel B, all-zero when idle.
- `id_a`  out  4  index of channel A owner, 0 when idle.
- `id_b`  out  4  index of channel B owner, 0 when idle.
- `busy`  out  2  {B busy, A busy}.

## Operation
- Per-channel FSM, states IDLE and GRANT; all outputs registered, decoded from state and owner index.
- Candidate set = `req` minus current owners of A and B (a requester never holds both channels).
- Selection, fixed priority: 12 highest, 1 lowest; `first` = highest candidate, `second` = next highest.
- Allocation in a cycle:
  - both IDLE: A <- `first`, B <- `second`;
  - only A IDLE: A <- `first`;
  - only B IDLE: B <- `first`;
  - no candidate: channel stays IDLE.
- GRANT -> IDLE when `done_x`=1 or `req[id_x]`=0 (withdrawal). Released channel is not reallocated in the same edge; it is eligible again next cycle.
- `done_x` in IDLE is ignored.
- Both channels releasing in the same cycle: both go IDLE, next allocation uses both-IDLE rule.
- Requester released by A and still requesting is an ordinary candidate next cycle.

## Timing
- Reset: both channels IDLE, `grant_a`=`grant_b`=0, `id_a`=`id_b`=0, `busy`=2'b00, rotation pointer (if enabled) = 12. Reset mid-grant drops all grants on the next edge regardless of `req`/`done`.
- Grant latency: `req` high in cycle t (channel IDLE) -> grant visible in cycle t+1.
- Release latency: `done_x` or withdrawal in cycle t -> channel IDLE in t+1, new owner earliest t+2.
- Grant is stable for the whole GRANT state; owner changes only via IDLE.
- Minimum occupancy: 1 cycle (done in first granted cycle).

## Configuration
- `DUAL_GRANT_RR_EN` defined: rotating priority. 4-bit pointer `ptr` (1..12) names the highest-priority index; order descends from `ptr` with wrap 1 -> 12. On every grant, `ptr` <- granted index - 1 (wrap 0 -> 12); on a double grant, the `second` index is used. Pointer unchanged on cycles with no new grant.
- Not defined: fixed priority 12 > 11 > ... > 1, no pointer register.

## Test plan
- Reset, then `req`=12'h000 for 5 cycles -> `id_a`=`id_b`=0, `busy`=0 throughout.
- From IDLE, `req` bits 9 and 4 raised in cycle 0 -> cycle 1: `id_a`=9, `id_b`=4, `grant_a`=12'h100, `grant_b`=12'h008, `busy`=2'b11.
- A owns 9, B owns 4, req 12 pending; pulse `done_b` -> B IDLE next cycle, then `id_b`=12 the cycle after; `id_a` stays 9 throughout.
- A owns 7; drop `req[7]` -> A IDLE next cycle without `done_a`; `done_a` pulsed while IDLE -> no change.
- Reset asserted while A owns 5 and B owns 3 -> next edge all outputs 0; `req` held with reset deasserted -> 5/3 regranted one cycle later.
- `DUAL_GRANT_RR_EN`: `req` bits 12, 11, 2 held, channel A only (B kept busy), each grant completed with `done_a` -> A owner sequence 12, 11, 2, 12 (fixed-priority build: 12, 12, 12, 12).
